// File: rtl/encode_decode_8b10b.sv
// 8b/10b line codec: registered encoder with running disparity, combinational table decoder.
// Optional CODE_ERR_EN adds a code_err output that flags symbols outside both RD columns.
module encode_decode_8b10b (
  input  logic       clk,
  input  logic       rst,
  input  logic       nextword_enable,
  input  logic       idle,
  input  logic [7:0] d_in,
  output logic [9:0] enc_out,
  input  logic [9:0] dec_in,
  output logic [7:0] dec_out,
  output logic       dec_k
`ifdef CODE_ERR_EN
  ,
  output logic       code_err
`endif
);

  // RD- column of the 5b/6b table, abcdei order
  function automatic logic [5:0] code6(input logic [4:0] x);
    case (x)
      5'd0:  code6 = 6'b100111;
      5'd1:  code6 = 6'b011101;
      5'd2:  code6 = 6'b101101;
      5'd3:  code6 = 6'b110001;
      5'd4:  code6 = 6'b110101;
      5'd5:  code6 = 6'b101001;
      5'd6:  code6 = 6'b011001;
      5'd7:  code6 = 6'b111000;
      5'd8:  code6 = 6'b111001;
      5'd9:  code6 = 6'b100101;
      5'd10: code6 = 6'b010101;
      5'd11: code6 = 6'b110100;
      5'd12: code6 = 6'b001101;
      5'd13: code6 = 6'b101100;
      5'd14: code6 = 6'b011100;
      5'd15: code6 = 6'b010111;
      5'd16: code6 = 6'b011011;
      5'd17: code6 = 6'b100011;
      5'd18: code6 = 6'b010011;
      5'd19: code6 = 6'b110010;
      5'd20: code6 = 6'b001011;
      5'd21: code6 = 6'b101010;
      5'd22: code6 = 6'b011010;
      5'd23: code6 = 6'b111010;
      5'd24: code6 = 6'b110011;
      5'd25: code6 = 6'b100110;
      5'd26: code6 = 6'b010110;
      5'd27: code6 = 6'b110110;
      5'd28: code6 = 6'b001110;
      5'd29: code6 = 6'b101110;
      5'd30: code6 = 6'b011110;
      default: code6 = 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] code4(input logic [2:0] y);
    case (y)
      3'd0: code4 = 4'b1011;
      3'd1: code4 = 4'b1001;
      3'd2: code4 = 4'b0101;
      3'd3: code4 = 4'b1100;
      3'd4: code4 = 4'b1101;
      3'd5: code4 = 4'b1010;
      3'd6: code4 = 4'b0110;
      default: code4 = 4'b1110;
    endcase
  endfunction

  // K28.y fghj as sent after a negative 6b sub-block (110000)
  function automatic logic [3:0] kcode4(input logic [2:0] y);
    case (y)
      3'd0: kcode4 = 4'b1011;
      3'd1: kcode4 = 4'b0110;
      3'd2: kcode4 = 4'b1010;
      3'd3: kcode4 = 4'b1100;
      3'd4: kcode4 = 4'b1101;
      3'd5: kcode4 = 4'b0101;
      3'd6: kcode4 = 4'b1001;
      default: kcode4 = 4'b0111;
    endcase
  endfunction

  // RD+ form: unbalanced codes and the two polarity-dependent balanced codes invert
  function automatic logic [5:0] alt6(input logic [5:0] c);
    alt6 = ($countones(c) != 3 || c == 6'b111000) ? ~c : c;
  endfunction

  function automatic logic [3:0] alt4(input logic [3:0] c);
    alt4 = ($countones(c) != 2 || c == 4'b1100) ? ~c : c;
  endfunction

  // Returns {rd_after, abcdei, fghj}; k selects K28.5 and ignores d
  function automatic logic [10:0] encode(input logic [7:0] d, input logic k, input logic rd);
    logic [5:0] c6;
    logic [3:0] c4;
    logic       unbal6, unbal4, rd6, use_a7;
    c6     = k ? 6'b001111 : code6(d[4:0]);
    unbal6 = ($countones(c6) != 3);
    rd6    = rd ^ unbal6;
    use_a7 = (d[7:5] == 3'd7) &&
             ((!rd6 && (d[4:0] == 5'd17 || d[4:0] == 5'd18 || d[4:0] == 5'd20)) ||
              ( rd6 && (d[4:0] == 5'd11 || d[4:0] == 5'd13 || d[4:0] == 5'd14)));
    if (k)           c4 = 4'b0101;
    else if (use_a7) c4 = 4'b0111;
    else             c4 = code4(d[7:5]);
    unbal4     = ($countones(c4) != 2);
    encode[10] = rd6 ^ unbal4;
    encode[9:4] = rd ? alt6(c6) : c6;
    encode[3:0] = rd6 ? (k ? ~c4 : alt4(c4)) : c4;
  endfunction

  logic        rd;
  logic [10:0] next_word;

  always_comb begin
    next_word = idle ? encode(8'hBC, 1'b1, rd) : encode(d_in, 1'b0, rd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd      <= 1'b0;
      enc_out <= 10'b0011111010;
    end else if (nextword_enable) begin
      rd      <= next_word[10];
      enc_out <= next_word[9:0];
    end
  end

  logic [5:0] s6;
  logic [3:0] s4;
  logic [4:0] x_dec;
  logic [2:0] y_dec, k_y;
  logic [7:0] d_cand;
  logic       d_legal, k28_legal, k7_legal;

  assign s6 = dec_in[9:4];
  assign s4 = dec_in[3:0];

  // Candidate byte from independent sub-block lookups; legality is proven by re-encoding
  always_comb begin
    x_dec = 5'd0;
    y_dec = 3'd0;
    for (int i = 0; i < 32; i++) begin
      if (s6 == code6(5'(i)) || s6 == alt6(code6(5'(i)))) x_dec = 5'(i);
    end
    for (int j = 0; j < 8; j++) begin
      if (s4 == code4(3'(j)) || s4 == alt4(code4(3'(j)))) y_dec = 3'(j);
    end
    if (s4 == 4'b0111 || s4 == 4'b1000) y_dec = 3'd7;
  end

  assign d_cand  = {y_dec, x_dec};
  assign d_legal = ((encode(d_cand, 1'b0, 1'b0) & 11'h3FF) == {1'b0, dec_in}) ||
                   ((encode(d_cand, 1'b0, 1'b1) & 11'h3FF) == {1'b0, dec_in});

  always_comb begin
    k28_legal = 1'b0;
    k_y       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((s6 == 6'b001111 && s4 == ~kcode4(3'(i))) ||
          (s6 == 6'b110000 && s4 ==  kcode4(3'(i)))) begin
        k28_legal = 1'b1;
        k_y       = 3'(i);
      end
    end
  end

  assign k7_legal = (x_dec == 5'd23 || x_dec == 5'd27 || x_dec == 5'd29 || x_dec == 5'd30) &&
                    ((s6 == code6(x_dec) && s4 == 4'b1000) ||
                     (s6 == ~code6(x_dec) && s4 == 4'b0111));

  always_comb begin
    dec_k = k28_legal | k7_legal;
    if (k28_legal)     dec_out = {k_y, 5'd28};
    else if (k7_legal) dec_out = {3'd7, x_dec};
    else if (d_legal)  dec_out = d_cand;
    else               dec_out = 8'h00;
  end

`ifdef CODE_ERR_EN
  assign code_err = !(k28_legal | k7_legal | d_legal);
`endif

endmodule

// File: tb/tb_encode_decode_8b10b.sv
// Self-checking bench for encode_decode_8b10b against a table-driven 8b/10b reference model.
// Checks code_err as well when CODE_ERR_EN is defined.
`timescale 1ns/1ps
module tb_encode_decode_8b10b;

  logic       clk = 1'b0;
  logic       rst;
  logic       nextword_enable;
  logic       idle;
  logic [7:0] d_in;
  logic [9:0] enc_out;
  logic [9:0] dec_in;
  logic [7:0] dec_out;
  logic       dec_k;
`ifdef CODE_ERR_EN
  logic       code_err;
`endif

  int check_count = 0;
  int pass_count  = 0;

  encode_decode_8b10b dut (
    .clk(clk),
    .rst(rst),
    .nextword_enable(nextword_enable),
    .idle(idle),
    .d_in(d_in),
    .enc_out(enc_out),
    .dec_in(dec_in),
    .dec_out(dec_out),
    .dec_k(dec_k)
`ifdef CODE_ERR_EN
    ,
    .code_err(code_err)
`endif
  );

  always #5 clk = ~clk;

  // Standard code tables, both running-disparity columns written out explicitly
  localparam logic [5:0] NEG6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] POS6 [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] NEG4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] POS4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4N  [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};

  // Reference encoder: column picked by current disparity, disparity recomputed by counting ones
  function automatic logic [10:0] ref_sym(input int val, input bit is_k, input bit rd_pos);
    int x, y, ones;
    bit rd6, rd_out;
    logic [5:0] b6;
    logic [3:0] b4;
    x = val % 32;
    y = val / 32;
    if (is_k && x == 28) b6 = rd_pos ? 6'b110000 : 6'b001111;
    else                 b6 = rd_pos ? POS6[x] : NEG6[x];
    ones = $countones(b6);
    rd6  = (ones > 3) ? 1'b1 : (ones < 3) ? 1'b0 : rd_pos;
    if (is_k) b4 = rd6 ? ~K4N[y] : K4N[y];
    else if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) ||
                        ( rd6 && (x == 11 || x == 13 || x == 14))))
      b4 = rd6 ? 4'b1000 : 4'b0111;
    else b4 = rd6 ? POS4[y] : NEG4[y];
    ones   = $countones(b4);
    rd_out = (ones > 2) ? 1'b1 : (ones < 2) ? 1'b0 : rd6;
    return {rd_out, b6, b4};
  endfunction

  logic [7:0] dmap   [1024];
  bit         dvalid [1024];
  bit         kvalid [1024];
  bit         m_rd;
  logic [9:0] m_sym;
  logic [7:0] m_val;
  bit         m_k;

  task automatic build_maps();
    logic [10:0] t;
    int klist [12] = '{28, 60, 92, 124, 156, 188, 220, 252, 247, 251, 253, 254};
    for (int d = 0; d < 256; d++) begin
      for (int r = 0; r < 2; r++) begin
        t = ref_sym(d, 1'b0, r[0]);
        dmap[t[9:0]]   = d[7:0];
        dvalid[t[9:0]] = 1'b1;
      end
    end
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < 2; r++) begin
        t = ref_sym(klist[i], 1'b1, r[0]);
        dmap[t[9:0]]   = klist[i][7:0];
        kvalid[t[9:0]] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_rd  = 1'b0;
    m_sym = 10'b0011111010;
    m_val = 8'hBC;
    m_k   = 1'b1;
  endtask

  task automatic tick(input bit en, input bit idl, input logic [7:0] d);
    @(negedge clk);
    nextword_enable = en;
    idle            = idl;
    d_in            = d;
    @(posedge clk);
    if (en) begin
      {m_rd, m_sym} = ref_sym(idl ? 188 : int'(d), idl, m_rd);
      m_val = idl ? 8'hBC : d;
      m_k   = idl;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; nextword_enable = 1'b0; idle = 1'b0; d_in = 8'h00; dec_in = 10'h000;
    #12;
    rst = 1'b1;
    model_reset();
    #1;
    check_count++;
    if (enc_out !== 10'b0011111010) $display("[TB] FAIL reset_enc: got %b expected %b", enc_out, 10'b0011111010);
    else pass_count++;
    dec_in = enc_out;
    #1;
    check_count++;
    if (dec_out !== 8'hBC) $display("[TB] FAIL reset_dec_out: got %h expected bc", dec_out);
    else pass_count++;
    check_count++;
    if (dec_k !== 1'b1) $display("[TB] FAIL reset_dec_k: got %b expected 1", dec_k);
    else pass_count++;
  endtask

  task automatic test_data_zero();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      check_count++;
      if (enc_out !== 10'b1001110100) $display("[TB] FAIL d0_0[%0d]: got %b expected %b", i, enc_out, 10'b1001110100);
      else pass_count++;
    end
  endtask

  task automatic test_idle_alternate();
    logic [9:0] exp;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 8'($urandom));
      exp = (i % 2 == 0) ? 10'b0011111010 : 10'b1100000101;
      check_count++;
      if (enc_out !== exp) $display("[TB] FAIL idle_alt[%0d]: got %b expected %b", i, enc_out, exp);
      else pass_count++;
    end
  endtask

  task automatic test_d21_5();
    logic [9:0] exp_k [2] = '{10'b0011111010, 10'b1100000101};
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 8'hB5);
      check_count++;
      if (enc_out !== 10'b1010101010) $display("[TB] FAIL d21_5[%0d]: got %b expected %b", i, enc_out, 10'b1010101010);
      else pass_count++;
      tick(1'b1, 1'b1, 8'h00);
      check_count++;
      if (enc_out !== exp_k[i]) $display("[TB] FAIL d21_5_rd[%0d]: got %b expected %b", i, enc_out, exp_k[i]);
      else pass_count++;
    end
  endtask

  task automatic test_loopback_sweep();
    for (int i = 0; i < 256; i++) begin
      tick(1'b1, 1'b0, i[7:0]);
      check_count++;
      if (enc_out !== m_sym) $display("[TB] FAIL sweep_enc[%0d]: got %b expected %b", i, enc_out, m_sym);
      else pass_count++;
      dec_in = enc_out;
      #1;
      check_count++;
      if (dec_out !== i[7:0]) $display("[TB] FAIL sweep_dec[%0d]: got %h expected %h", i, dec_out, i[7:0]);
      else pass_count++;
      check_count++;
      if (dec_k !== 1'b0) $display("[TB] FAIL sweep_k[%0d]: got %b expected 0", i, dec_k);
      else pass_count++;
`ifdef CODE_ERR_EN
      check_count++;
      if (code_err !== 1'b0) $display("[TB] FAIL sweep_err[%0d]: got %b expected 0", i, code_err);
      else pass_count++;
`endif
    end
  endtask

  task automatic test_hold();
    logic [9:0] held;
    held = m_sym;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'($urandom), 8'($urandom));
      check_count++;
      if (enc_out !== held) $display("[TB] FAIL hold[%0d]: got %b expected %b", i, enc_out, held);
      else pass_count++;
    end
    dec_in = 10'h000;
    #1;
    check_count++;
    if (dec_out !== 8'h00) $display("[TB] FAIL hold_dec_zero: got %h expected 00", dec_out);
    else pass_count++;
`ifdef CODE_ERR_EN
    check_count++;
    if (code_err !== 1'b1) $display("[TB] FAIL hold_code_err: got %b expected 1", code_err);
    else pass_count++;
`endif
    tick(1'b1, 1'b0, 8'($urandom));
    check_count++;
    if (enc_out !== m_sym) $display("[TB] FAIL hold_resume: got %b expected %b", enc_out, m_sym);
    else pass_count++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, 8'($urandom));
      check_count++;
      if (enc_out !== m_sym) $display("[TB] FAIL rand_enc[%0d]: got %b expected %b", i, enc_out, m_sym);
      else pass_count++;
      dec_in = enc_out;
      #1;
      check_count++;
      if (dec_out !== m_val || dec_k !== m_k)
        $display("[TB] FAIL rand_dec[%0d]: got %h/%b expected %h/%b", i, dec_out, dec_k, m_val, m_k);
      else pass_count++;
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 2 && !m_rd; i++) tick(1'b1, 1'b1, 8'h00);
    check_count++;
    if (enc_out !== m_sym || m_rd !== 1'b1) $display("[TB] FAIL mid_setup: got %b expected %b rd+", enc_out, m_sym);
    else pass_count++;
    #3;
    nextword_enable = 1'b1;
    idle = 1'b0;
    d_in = 8'($urandom);
    rst = 1'b0;
    #1;
    check_count++;
    if (enc_out !== 10'b0011111010) $display("[TB] FAIL mid_async: got %b expected %b", enc_out, 10'b0011111010);
    else pass_count++;
    @(posedge clk);
    #1;
    check_count++;
    if (enc_out !== 10'b0011111010) $display("[TB] FAIL mid_held: got %b expected %b", enc_out, 10'b0011111010);
    else pass_count++;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 8'($urandom));
      check_count++;
      if (enc_out !== m_sym) $display("[TB] FAIL mid_after[%0d]: got %b expected %b", i, enc_out, m_sym);
      else pass_count++;
    end
  endtask

  task automatic test_decoder_table();
    logic [7:0] exp_out;
    bit         exp_k;
    for (int s = 0; s < 1024; s++) begin
      dec_in  = s[9:0];
      exp_k   = kvalid[s];
      exp_out = (kvalid[s] || dvalid[s]) ? dmap[s] : 8'h00;
      #1;
      check_count++;
      if (dec_out !== exp_out || dec_k !== exp_k)
        $display("[TB] FAIL dec_table[%b]: got %h/%b expected %h/%b", s[9:0], dec_out, dec_k, exp_out, exp_k);
      else pass_count++;
`ifdef CODE_ERR_EN
      check_count++;
      if (code_err !== !(kvalid[s] || dvalid[s]))
        $display("[TB] FAIL dec_err[%b]: got %b expected %b", s[9:0], code_err, !(kvalid[s] || dvalid[s]));
      else pass_count++;
`endif
    end
  endtask

  initial begin
    build_maps();
    test_reset();
    test_data_zero();
    test_idle_alternate();
    test_d21_5();
    test_loopback_sweep();
    test_hold();
    test_random();
    test_reset_midstream();
    test_decoder_table();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
